// File: rtl/sdc_pkg.sv
// Shared types and constants for the floppy sector server.
package sdc_pkg;

  localparam int SECTOR_BYTES     = 512;
  localparam int WORDS_PER_SECTOR = 256;
  localparam int NUM_DRIVES       = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT_HI,
    S_EMIT_LO,
    S_GAP,
    S_DONE,
    S_RELEASE
  } state_e;

  // Lowest-numbered requesting drive wins.
  function automatic logic [1:0] lowestDrive(input logic [NUM_DRIVES-1:0] req);
    logic [1:0] drv;
    drv = 2'd0;
    for (int i = NUM_DRIVES - 1; i >= 0; i--) begin
      if (req[i]) drv = 2'(i);
    end
    return drv;
  endfunction

endpackage

// File: rtl/sdc_sector_server.sv
// Serves one 512-byte sector per request from a word-addressed image store,
// pacing the bytes out on the strobe interface with a programmable gap.
module sdc_sector_server
  import sdc_pkg::*;
#(
  parameter int SECTOR_BITS = 11,
  parameter int BYTE_GAP    = 3
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_DRIVES-1:0]       sdc_rd,
  input  logic [31:0]                 sdc_sector,
  output logic                        sdc_busy,
  output logic                        sdc_done,
  output logic                        sdc_byte_in_strobe,
  output logic [8:0]                  sdc_byte_in_addr,
  output logic [7:0]                  sdc_byte_in_data,
  output logic                        sdc_err,
  output logic                        mem_rd,
  output logic [2+SECTOR_BITS+8-1:0]  mem_addr,
  input  logic                        mem_ack,
  input  logic [15:0]                 mem_data
);

  localparam logic [15:0] GapLast = (BYTE_GAP > 1) ? 16'(BYTE_GAP - 2) : 16'd0;

  state_e                 state_q, state_d;
  logic [1:0]             drive_q, drive_d;
  logic [SECTOR_BITS-1:0] sector_q, sector_d;
  logic [7:0]             word_q, word_d;
  logic                   err_q, err_d;
  logic [7:0]             lo_q, lo_d;
  logic [15:0]            gap_q, gap_d;
  logic                   gapToLo_q, gapToLo_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   strobe_q, strobe_d;
  logic [8:0]             addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic                   memRd_q, memRd_d;
  logic                   goLo, goNext;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      drive_q   <= '0;
      sector_q  <= '0;
      word_q    <= '0;
      err_q     <= 1'b0;
      lo_q      <= '0;
      gap_q     <= '0;
      gapToLo_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      strobe_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      memRd_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      drive_q   <= drive_d;
      sector_q  <= sector_d;
      word_q    <= word_d;
      err_q     <= err_d;
      lo_q      <= lo_d;
      gap_q     <= gap_d;
      gapToLo_q <= gapToLo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      strobe_q  <= strobe_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      memRd_q   <= memRd_d;
    end
  end

  // All outputs are registered from the next state, so they line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    drive_d   = drive_q;
    sector_d  = sector_q;
    word_d    = word_q;
    err_d     = err_q;
    lo_d      = lo_q;
    gap_d     = gap_q;
    gapToLo_d = gapToLo_q;
    strobe_d  = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    goLo      = 1'b0;
    goNext    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (sdc_rd != '0) begin
          drive_d  = lowestDrive(sdc_rd);
          sector_d = sdc_sector[SECTOR_BITS-1:0];
          err_d    = (sdc_sector >> SECTOR_BITS) != 32'd0;
          word_d   = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (err_q || mem_ack) begin
          lo_d     = err_q ? 8'h00 : mem_data[7:0];
          data_d   = err_q ? 8'h00 : mem_data[15:8];
          addr_d   = {word_q, 1'b0};
          strobe_d = 1'b1;
          state_d  = S_EMIT_HI;
        end
      end
      S_EMIT_HI: begin
        if (BYTE_GAP == 1) begin
          goLo = 1'b1;
        end else begin
          state_d   = S_GAP;
          gap_d     = '0;
          gapToLo_d = 1'b1;
        end
      end
      S_EMIT_LO: begin
        if (BYTE_GAP == 1) begin
          goNext = 1'b1;
        end else begin
          state_d   = S_GAP;
          gap_d     = '0;
          gapToLo_d = 1'b0;
        end
      end
      S_GAP: begin
        if (gap_q == GapLast) begin
          goLo   = gapToLo_q;
          goNext = !gapToLo_q;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      S_DONE:    state_d = S_RELEASE;
      S_RELEASE: if (!sdc_rd[drive_q]) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (goLo) begin
      state_d  = S_EMIT_LO;
      strobe_d = 1'b1;
      addr_d   = {word_q, 1'b1};
      data_d   = lo_q;
    end
    // The terminal word ends the sector instead of wrapping the counter.
    if (goNext) begin
      if (word_q == 8'hFF) begin
        state_d = S_DONE;
      end else begin
        state_d = S_FETCH;
        word_d  = word_q + 8'd1;
      end
    end

    busy_d  = (state_d == S_FETCH) || (state_d == S_EMIT_HI) ||
              (state_d == S_EMIT_LO) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
    memRd_d = (state_d == S_FETCH) && !err_d;
  end

  assign sdc_busy           = busy_q;
  assign sdc_done           = done_q;
  assign sdc_byte_in_strobe = strobe_q;
  assign sdc_byte_in_addr   = addr_q;
  assign sdc_byte_in_data   = data_q;
  assign sdc_err            = err_q;
  assign mem_rd             = memRd_q;
  assign mem_addr           = {drive_q, sector_q, word_q};

endmodule

// File: tb/tb_sdc_sector_server.sv
// Directed and randomized checks of the sector server against a behavioural
// model of the image store and the byte/timing rules of the strobe interface.
module tb_sdc_sector_server;

  localparam int GAP = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  sdc_rd = '0;
  logic [31:0] sdc_sector = '0;
  logic        sdc_busy, sdc_done, sdc_byte_in_strobe, sdc_err, mem_rd;
  logic [8:0]  sdc_byte_in_addr;
  logic [7:0]  sdc_byte_in_data;
  logic [20:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = '0;

  logic [3:0]  sdc_rd1 = '0;
  logic [31:0] sdc_sector1 = 32'd7;
  logic        busy1, done1, strobe1, err1, mem_rd1, mem_ack1;
  logic [8:0]  addr1;
  logic [7:0]  data1;
  logic [20:0] mem_addr1;
  logic [15:0] mem_data1;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;

  int          memLat = 2;
  logic [15:0] memBase = 16'hA500;
  logic [15:0] memMix = 16'h0000;
  bit          spurious = 1'b1;
  int          waitCnt = 0;

  logic [8:0]  stbAddr[$];
  logic [7:0]  stbData[$];
  int          stbCyc[$];
  int          ackCyc[$];
  logic [20:0] ackAddr[$];
  int          rdRise[$];
  int doneCount = 0, doneCyc = 0, busyRises = 0, busyRiseCyc = 0;
  int memRdCycles = 0, adjacent = 0;
  bit prevStb = 0, prevRd = 0, prevBusy = 0;

  int stb1Cyc[$];
  logic [8:0] stb1Addr[$];
  logic [7:0] stb1Data[$];
  int done1Count = 0, done1Cyc = 0;

  sdc_sector_server #(.SECTOR_BITS(11), .BYTE_GAP(GAP)) dut (
    .clk(clk), .rstn(rstn), .sdc_rd(sdc_rd), .sdc_sector(sdc_sector),
    .sdc_busy(sdc_busy), .sdc_done(sdc_done), .sdc_byte_in_strobe(sdc_byte_in_strobe),
    .sdc_byte_in_addr(sdc_byte_in_addr), .sdc_byte_in_data(sdc_byte_in_data),
    .sdc_err(sdc_err), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data)
  );

  sdc_sector_server #(.SECTOR_BITS(11), .BYTE_GAP(1)) dutGap1 (
    .clk(clk), .rstn(rstn), .sdc_rd(sdc_rd1), .sdc_sector(sdc_sector1),
    .sdc_busy(busy1), .sdc_done(done1), .sdc_byte_in_strobe(strobe1),
    .sdc_byte_in_addr(addr1), .sdc_byte_in_data(data1),
    .sdc_err(err1), .mem_rd(mem_rd1), .mem_addr(mem_addr1),
    .mem_ack(mem_ack1), .mem_data(mem_data1)
  );

  // Zero-wait store for the gap-1 instance: acknowledge in the first read cycle.
  assign mem_ack1  = mem_rd1;
  assign mem_data1 = {8'h3C, mem_addr1[7:0]};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference image contents as a function of drive, sector and word.
  function automatic logic [15:0] imgWord(input logic [1:0] d, input logic [10:0] s, input logic [7:0] w);
    return memBase + {8'h00, w} + (memMix & {d, s[5:0], 8'h00});
  endfunction

  // Image store responder with a configurable wait and occasional stray acks while idle.
  initial begin
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_rd) begin
        if (waitCnt == memLat) begin
          mem_ack  = 1'b1;
          mem_data = imgWord(mem_addr[20:19], mem_addr[18:8], mem_addr[7:0]);
          ackCyc.push_back(cyc);
          ackAddr.push_back(mem_addr);
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
        if (spurious && $urandom_range(0, 7) == 0) begin
          mem_ack  = 1'b1;
          mem_data = 16'($urandom);
        end
      end
    end
  end

  // Event recorder for both instances.
  initial begin
    forever begin
      @(negedge clk);
      if (sdc_byte_in_strobe) begin
        stbAddr.push_back(sdc_byte_in_addr);
        stbData.push_back(sdc_byte_in_data);
        stbCyc.push_back(cyc);
        if (prevStb) adjacent++;
      end
      prevStb = sdc_byte_in_strobe;
      if (mem_rd && !prevRd) rdRise.push_back(cyc);
      prevRd = mem_rd;
      if (mem_rd) memRdCycles++;
      if (sdc_busy && !prevBusy) begin
        busyRises++;
        busyRiseCyc = cyc;
      end
      prevBusy = sdc_busy;
      if (sdc_done) begin
        doneCount++;
        doneCyc = cyc;
      end
      if (strobe1) begin
        stb1Cyc.push_back(cyc);
        stb1Addr.push_back(addr1);
        stb1Data.push_back(data1);
      end
      if (done1) begin
        done1Count++;
        done1Cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearLogs();
    stbAddr.delete(); stbData.delete(); stbCyc.delete();
    ackCyc.delete(); ackAddr.delete(); rdRise.delete();
    doneCount = 0; busyRises = 0; memRdCycles = 0; adjacent = 0;
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] sec, output int reqCyc);
    tick();
    clearLogs();
    sdc_sector = sec;
    sdc_rd     = mask;
    reqCyc     = cyc;
  endtask

  task automatic releaseReq();
    tick();
    sdc_rd = '0;
    tick();
    tick();
  endtask

  // Waits for the end of the sector, then checks data, addresses and timing.
  task automatic waitSector(input string tag, input logic [1:0] drv, input logic [31:0] sec,
                            input int reqCyc, input int lat);
    int budget, bad, addrBad, timeBad, lastStb;
    logic expErr;
    logic [15:0] wd;
    logic [7:0] expB;
    expErr = (sec >= 32'd2048);
    budget = 0;
    while (doneCount == 0 && budget < 6000) begin
      tick();
      budget++;
    end
    checkOutput({tag, "_done_count"}, 32'(doneCount), 32'd1);
    checkOutput({tag, "_busy_at_done"}, 32'(sdc_busy), 32'd0);
    checkOutput({tag, "_err"}, 32'(sdc_err), 32'(expErr));
    checkOutput({tag, "_strobes"}, 32'(stbAddr.size()), 32'd512);
    bad = 0;
    for (int i = 0; i < stbAddr.size(); i++) begin
      wd   = expErr ? 16'h0000 : imgWord(drv, sec[10:0], 8'(i / 2));
      expB = (i % 2 == 0) ? wd[15:8] : wd[7:0];
      if (stbAddr[i] !== 9'(i) || stbData[i] !== expB) bad++;
    end
    checkOutput({tag, "_bytes"}, 32'(bad), 32'd0);
    checkOutput({tag, "_adjacent"}, 32'(adjacent), 32'd0);
    addrBad = 0;
    timeBad = 0;
    if (expErr) begin
      checkOutput({tag, "_memrd_cycles"}, 32'(memRdCycles), 32'd0);
      if (stbCyc.size() != 512 || reqCyc < 0) timeBad++;
      else for (int i = 0; i < 512; i++)
        if (stbCyc[i] != reqCyc + 2 + (i / 2) * (2 * GAP + 1) + (i % 2) * GAP) timeBad++;
    end else begin
      checkOutput({tag, "_acks"}, 32'(ackAddr.size()), 32'd256);
      if (lat >= 0) checkOutput({tag, "_memrd_cycles"}, 32'(memRdCycles), 32'(256 * (lat + 1)));
      if (ackCyc.size() != 256 || rdRise.size() != 256 || stbCyc.size() != 512) timeBad++;
      else for (int w = 0; w < 256; w++) begin
        if (ackAddr[w] !== {drv, sec[10:0], 8'(w)}) addrBad++;
        if (stbCyc[2 * w] != ackCyc[w] + 1) timeBad++;
        if (stbCyc[2 * w + 1] != ackCyc[w] + 1 + GAP) timeBad++;
        if (w < 255 && rdRise[w + 1] != ackCyc[w] + 1 + 2 * GAP) timeBad++;
        if (lat >= 0 && ackCyc[w] != rdRise[w] + lat) timeBad++;
      end
      checkOutput({tag, "_mem_addr"}, 32'(addrBad), 32'd0);
      if (reqCyc >= 0 && rdRise.size() > 0)
        checkOutput({tag, "_memrd_rise"}, 32'(rdRise[0]), 32'(reqCyc + 1));
    end
    checkOutput({tag, "_timing"}, 32'(timeBad), 32'd0);
    if (reqCyc >= 0) checkOutput({tag, "_busy_rise"}, 32'(busyRiseCyc), 32'(reqCyc + 1));
    lastStb = (stbCyc.size() == 512) ? stbCyc[511] : 0;
    checkOutput({tag, "_done_gap"}, 32'(doneCyc - lastStb), 32'(GAP));
  endtask

  initial begin
    int n, n1, budget, bad;
    logic [31:0] s1, s2, sec;
    logic [1:0] drv;

    $display("[TB] starting sdc_sector_server bench");
    tick();
    tick();
    checkOutput("reset_busy", 32'(sdc_busy), 32'd0);
    checkOutput("reset_strobe", 32'(sdc_byte_in_strobe), 32'd0);
    checkOutput("reset_memrd", 32'(mem_rd), 32'd0);
    checkOutput("reset_outputs", {sdc_done, sdc_err, sdc_byte_in_addr, sdc_byte_in_data, mem_addr[12:0]}, 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Single read: drive 0, sector 5, words A500+w, two wait cycles.
    memLat = 2; memBase = 16'hA500; memMix = 16'h0000;
    applyStimulus(4'b0001, 32'd5, n);
    waitSector("single", 2'd0, 32'd5, n, 2);

    // Held request must not be served a second time.
    tick();
    clearLogs();
    repeat (2000) tick();
    checkOutput("held_no_resend", 32'(busyRises), 32'd0);
    checkOutput("held_no_strobes", 32'(stbAddr.size()), 32'd0);
    tick();
    sdc_rd = '0;
    repeat (3) tick();
    checkOutput("held_dropped_idle", 32'(busyRises), 32'd0);

    memMix = 16'hFFFF; memBase = 16'($urandom); memLat = 0;
    sec = 32'($urandom_range(0, 2047));
    applyStimulus(4'b0001, sec, n);
    waitSector("reassert", 2'd0, sec, n, 0);
    releaseReq();

    // Simultaneous requests: drive 1 first, drive 3 once bit 1 drops.
    memLat = 1; memBase = 16'($urandom);
    s1 = 32'($urandom_range(0, 2047));
    s2 = 32'($urandom_range(0, 2047));
    applyStimulus(4'b1010, s1, n);
    repeat (40) tick();
    sdc_sector = 32'($urandom);
    waitSector("simul_d1", 2'd1, s1, n, 1);
    tick();
    sdc_sector = s2;
    clearLogs();
    repeat (5) tick();
    checkOutput("simul_release_hold", 32'(busyRises), 32'd0);
    tick();
    sdc_rd = 4'b1000;
    waitSector("simul_d3", 2'd3, s2, -1, 1);
    releaseReq();

    // Out of range sector.
    applyStimulus(4'b0100, 32'd2048, n);
    waitSector("range", 2'd2, 32'd2048, n, -1);
    releaseReq();

    for (int k = 0; k < 3; k++) begin
      drv     = 2'($urandom_range(0, 3));
      memLat  = $urandom_range(0, 3);
      memBase = 16'($urandom);
      sec     = (k == 1) ? (32'($urandom) | 32'h0000_0800) : 32'($urandom_range(0, 2047));
      applyStimulus(4'b0001 << drv, sec, n);
      waitSector($sformatf("rand%0d", k), drv, sec, n, memLat);
      releaseReq();
    end

    // BYTE_GAP=1 with zero-wait store: three cycles per word.
    tick();
    stb1Cyc.delete(); stb1Addr.delete(); stb1Data.delete(); done1Count = 0;
    sdc_rd1 = 4'b0001;
    n1 = cyc;
    budget = 0;
    while (done1Count == 0 && budget < 2000) begin
      tick();
      budget++;
    end
    checkOutput("gap1_done_count", 32'(done1Count), 32'd1);
    checkOutput("gap1_strobes", 32'(stb1Cyc.size()), 32'd512);
    bad = 0;
    for (int i = 0; i < stb1Cyc.size(); i++) begin
      if (stb1Cyc[i] != n1 + 2 + 3 * (i / 2) + (i % 2)) bad++;
      if (stb1Addr[i] !== 9'(i)) bad++;
      if (stb1Data[i] !== ((i % 2 == 0) ? 8'h3C : 8'(i / 2))) bad++;
    end
    checkOutput("gap1_bytes_timing", 32'(bad), 32'd0);
    if (stb1Cyc.size() == 512)
      checkOutput("gap1_done_gap", 32'(done1Cyc - stb1Cyc[511]), 32'd1);
    tick();
    sdc_rd1 = '0;

    // Abort mid-sector with reset, then serve a fresh sector from byte 0.
    memLat = 1; memBase = 16'($urandom);
    sec = 32'($urandom_range(0, 2047));
    applyStimulus(4'b0001, sec, n);
    budget = 0;
    while (stbAddr.size() < 101 && budget < 3000) begin
      tick();
      budget++;
    end
    checkOutput("abort_reached_byte100", 32'(stbAddr.size()), 32'd101);
    rstn = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(sdc_busy), 32'd0);
    checkOutput("abort_strobe_memrd", {30'd0, sdc_byte_in_strobe, mem_rd}, 32'd0);
    checkOutput("abort_outputs", {sdc_done, sdc_err, sdc_byte_in_addr, sdc_byte_in_data, mem_addr[12:0]}, 32'd0);
    sdc_rd = '0;
    repeat (3) tick();
    checkOutput("abort_no_done", 32'(doneCount), 32'd0);
    rstn = 1'b1;
    repeat (2) tick();
    sec = 32'($urandom_range(0, 2047));
    applyStimulus(4'b0010, sec, n);
    waitSector("after_abort", 2'd1, sec, n, 1);
    releaseReq();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
